// File: rtl/branch_target_predictor.sv
// Zero-latency next-PC predictor: direct-mapped BTB with 2-bit counters,
// JAL target decode and a circular return-address stack.
module branch_target_predictor #(
    parameter int WIDTH_PC  = 32,
    parameter int IDX_BITS  = 4,
    parameter int TAG_BITS  = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                fetch_valid,
    input  logic [WIDTH_PC-1:0] fetch_pc,
    input  logic [31:0]         fetch_inst,
    output logic                pred_taken,
    output logic [WIDTH_PC-1:0] pred_pc,
    input  logic                upd_valid,
    input  logic [WIDTH_PC-1:0] upd_pc,
    input  logic                upd_taken,
    input  logic [WIDTH_PC-1:0] upd_target,
    input  logic                upd_mispredict
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int PTR_W   = $clog2(RAS_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    localparam logic [CNT_W-1:0] RAS_FULL = CNT_W'(RAS_DEPTH);

    // BTB storage
    logic                btb_valid  [ENTRIES];
    logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
    logic [WIDTH_PC-1:0] btb_target [ENTRIES];
    logic [1:0]          btb_ctr    [ENTRIES];

    // RAS storage: ras_ptr points at the next free slot, top is ras_ptr-1
    logic [WIDTH_PC-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ras_ptr;
    logic [CNT_W-1:0]    ras_cnt;

    // Fetch-side decode
    logic [4:0]          opc;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic                is_jal;
    logic                is_jalr;
    logic                is_branch;
    logic                rd_link;
    logic                rs1_link;
    logic                is_call;
    logic                is_ret;
    logic [WIDTH_PC-1:0] j_imm;
    logic [WIDTH_PC-1:0] seq_pc;
    logic [WIDTH_PC-1:0] jal_pc;

    assign opc       = fetch_inst[6:2];
    assign rd        = fetch_inst[11:7];
    assign rs1       = fetch_inst[19:15];
    assign is_jal    = (opc == OP_JAL);
    assign is_jalr   = (opc == OP_JALR);
    assign is_branch = (opc == OP_BRANCH);
    assign rd_link   = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link  = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign is_call   = (is_jal || is_jalr) && rd_link;
    assign is_ret    = is_jalr && rs1_link && !rd_link;

    assign j_imm  = {{(WIDTH_PC-20){fetch_inst[31]}}, fetch_inst[19:12],
                     fetch_inst[20], fetch_inst[30:21], 1'b0};
    assign seq_pc = fetch_pc + WIDTH_PC'(4);
    assign jal_pc = fetch_pc + j_imm;

    // Fetch-side BTB lookup (reads pre-update contents)
    logic [IDX_BITS-1:0] f_idx;
    logic [TAG_BITS-1:0] f_tag;
    logic                f_hit;

    assign f_idx = fetch_pc[IDX_BITS+1:2];
    assign f_tag = fetch_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

    logic                ras_nonempty;
    logic [PTR_W-1:0]    ras_top_idx;

    assign ras_nonempty = (ras_cnt != '0);
    assign ras_top_idx  = ras_ptr - PTR_W'(1);

    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = seq_pc;
        if (is_jal) begin
            pred_taken = 1'b1;
            pred_pc    = jal_pc;
        end else if (is_ret && ras_nonempty) begin
            pred_taken = 1'b1;
            pred_pc    = ras_mem[ras_top_idx];
        end else if ((is_branch || is_jalr) && f_hit && btb_ctr[f_idx][1]) begin
            pred_taken = 1'b1;
            pred_pc    = btb_target[f_idx];
        end
    end

    // Update-side BTB lookup
    logic [IDX_BITS-1:0] u_idx;
    logic [TAG_BITS-1:0] u_tag;
    logic                u_hit;

    assign u_idx = upd_pc[IDX_BITS+1:2];
    assign u_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign u_hit = btb_valid[u_idx] && (btb_tag[u_idx] == u_tag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'd1;
            end
        end else if (upd_valid) begin
            if (u_hit) begin
                if (upd_taken) begin
                    btb_target[u_idx] <= upd_target;
                    if (btb_ctr[u_idx] != 2'd3)
                        btb_ctr[u_idx] <= btb_ctr[u_idx] + 2'd1;
                end else if (btb_ctr[u_idx] != 2'd0) begin
                    btb_ctr[u_idx] <= btb_ctr[u_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                btb_valid[u_idx]  <= 1'b1;
                btb_tag[u_idx]    <= u_tag;
                btb_target[u_idx] <= upd_target;
                btb_ctr[u_idx]    <= 2'd2;
            end
        end
    end

    logic do_push;
    logic do_pop;

    assign do_push = fetch_valid && is_call && !upd_mispredict;
    assign do_pop  = fetch_valid && is_ret && ras_nonempty && !upd_mispredict;

    // A redirect empties the stack and suppresses any same-cycle push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_mem[i] <= '0;
        end else if (upd_mispredict) begin
            ras_cnt <= '0;
        end else if (do_push) begin
            ras_mem[ras_ptr] <= seq_pc;
            ras_ptr          <= ras_ptr + PTR_W'(1);
            if (ras_cnt != RAS_FULL)
                ras_cnt <= ras_cnt + CNT_W'(1);
        end else if (do_pop) begin
            ras_ptr <= ras_top_idx;
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor with hand-computed next-PC values.
module tb_branch_target_predictor;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_inst;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    int checks = 0;
    int errors = 0;

    branch_target_predictor #(
        .WIDTH_PC(32), .IDX_BITS(4), .TAG_BITS(8), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
        .pred_taken(pred_taken), .pred_pc(pred_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_mispredict(upd_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] BEQ = 32'h0000_0063;

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h000, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_pred(input string tag, input logic t, input logic [31:0] pc);
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, t});
        check({tag, "_pc"}, pred_pc, pc);
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        fetch_valid = v;
        fetch_pc    = pc;
        fetch_inst  = inst;
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = t;
        upd_target = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        fetch_valid    = 1'b0;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        #1;
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        set_upd(pc, t, tgt);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0; fetch_pc = 32'h100; fetch_inst = BEQ;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_mispredict = 1'b0;
        #2;
        check_pred("rst_branch", 1'b0, 32'h104);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;

        // Cold miss then allocation
        fetch(1'b1, 32'h100, BEQ);
        check_pred("cold_0x100", 1'b0, 32'h104);
        step();
        update(32'h100, 1'b1, 32'h80);
        fetch(1'b1, 32'h100, BEQ);
        check_pred("alloc_0x100", 1'b1, 32'h80);
        step();

        // Counter walk: 2 -> 1 -> 0 -> 0, then up to 3 and back
        update(32'h100, 1'b0, 32'h0);
        fetch(1'b1, 32'h100, BEQ);
        check_pred("ctr1", 1'b0, 32'h104);
        update(32'h100, 1'b0, 32'h0);
        update(32'h100, 1'b0, 32'h0);
        fetch(1'b1, 32'h100, BEQ);
        check_pred("ctr0_sat", 1'b0, 32'h104);
        update(32'h100, 1'b1, 32'h80);
        fetch(1'b1, 32'h100, BEQ);
        check_pred("ctr_up1", 1'b0, 32'h104);
        update(32'h100, 1'b1, 32'h80);
        update(32'h100, 1'b1, 32'h80);
        update(32'h100, 1'b1, 32'h90);
        fetch(1'b1, 32'h100, BEQ);
        check_pred("ctr3_newtgt", 1'b1, 32'h90);
        update(32'h100, 1'b0, 32'h0);
        fetch(1'b1, 32'h100, BEQ);
        check_pred("ctr3_sat_dn2", 1'b1, 32'h90);
        update(32'h100, 1'b0, 32'h0);
        fetch(1'b1, 32'h100, BEQ);
        check_pred("ctr_dn1", 1'b0, 32'h104);

        // Alias at same index, different tag
        update(32'h100, 1'b1, 32'h80);
        fetch(1'b1, 32'h140, BEQ);
        check_pred("alias_miss", 1'b0, 32'h144);
        update(32'h140, 1'b1, 32'h300);
        fetch(1'b1, 32'h140, BEQ);
        check_pred("alias_alloc", 1'b1, 32'h300);
        fetch(1'b1, 32'h100, BEQ);
        check_pred("alias_evicted", 1'b0, 32'h104);
        update(32'h180, 1'b0, 32'h0);
        fetch(1'b1, 32'h140, BEQ);
        check_pred("nt_miss_nochg", 1'b1, 32'h300);

        // Same-cycle lookup sees pre-update state
        set_upd(32'h140, 1'b0, 32'h0);
        fetch(1'b1, 32'h140, BEQ);
        check_pred("bypass_pre", 1'b1, 32'h300);
        step();
        fetch(1'b1, 32'h140, BEQ);
        check_pred("bypass_post", 1'b0, 32'h144);

        // Call / return, including a fetch_valid=0 return that must not pop
        fetch(1'b1, 32'h200, enc_jal(5'd1, 21'h40));
        check_pred("jal_call", 1'b1, 32'h240);
        step();
        fetch(1'b0, 32'h250, enc_jalr(5'd0, 5'd1));
        check_pred("ret_novalid", 1'b1, 32'h204);
        step();
        fetch(1'b1, 32'h250, enc_jalr(5'd0, 5'd1));
        check_pred("ret_pop", 1'b1, 32'h204);
        step();
        fetch(1'b1, 32'h250, enc_jalr(5'd0, 5'd1));
        check_pred("ret_empty", 1'b0, 32'h254);
        step();

        // Five nested calls overflow a four-deep stack
        for (int i = 0; i < 4; i++) begin
            fetch(1'b1, 32'h400 + 32'(i) * 32'h100, enc_jal(5'd1, 21'h40));
            step();
        end
        fetch(1'b1, 32'h800, enc_jalr(5'd5, 5'd10));
        check_pred("jalr_call_miss", 1'b0, 32'h804);
        step();
        for (int i = 0; i < 4; i++) begin
            fetch(1'b1, 32'h900, enc_jalr(5'd0, (i == 1) ? 5'd5 : 5'd1));
            check_pred($sformatf("nest_ret%0d", i), 1'b1, 32'h804 - 32'(i) * 32'h100);
            step();
        end
        fetch(1'b1, 32'h900, enc_jalr(5'd0, 5'd1));
        check_pred("nest_ret_under", 1'b0, 32'h904);
        step();

        // Redirect clears the stack but the BTB update still lands
        fetch(1'b1, 32'h200, enc_jal(5'd1, 21'h40));
        set_upd(32'h3C8, 1'b1, 32'h500);
        upd_mispredict = 1'b1;
        step();
        fetch(1'b1, 32'h250, enc_jalr(5'd0, 5'd1));
        check_pred("misp_push_clr", 1'b0, 32'h254);
        fetch(1'b1, 32'h3C8, BEQ);
        check_pred("misp_btb_upd", 1'b1, 32'h500);
        fetch(1'b1, 32'h200, enc_jal(5'd1, 21'h40));
        step();
        fetch(1'b1, 32'h250, enc_jalr(5'd0, 5'd1));
        upd_mispredict = 1'b1;
        #1;
        check_pred("misp_pop_pre", 1'b1, 32'h204);
        step();
        fetch(1'b1, 32'h250, enc_jalr(5'd0, 5'd1));
        check_pred("misp_pop_clr", 1'b0, 32'h254);

        // Asynchronous reset in the middle of a push and an update
        fetch(1'b1, 32'h200, enc_jal(5'd1, 21'h40));
        set_upd(32'h140, 1'b1, 32'h600);
        #1;
        rst_n = 1'b0;
        step();
        #1;
        rst_n = 1'b1;
        #1;
        fetch(1'b1, 32'h250, enc_jalr(5'd0, 5'd1));
        check_pred("rst_ras_clr", 1'b0, 32'h254);
        fetch(1'b1, 32'h140, BEQ);
        check_pred("rst_btb_clr", 1'b0, 32'h144);
        fetch(1'b1, 32'h3C8, BEQ);
        check_pred("rst_btb_clr2", 1'b0, 32'h3CC);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 Parameter WIDTH_PC, 32, width of all PC and target buses.
REQ-002 Parameter IDX_BITS, 4, BTB index width; 2**IDX_BITS direct-mapped entries.
REQ-003 Parameter TAG_BITS, 8, BTB tag width.
REQ-004 Parameter RAS_DEPTH, 4, return-address-stack entries (power of two, >=2).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 fetch_valid  input  1  fetch_pc/fetch_inst valid and advancing this cycle.
REQ-008 fetch_pc  input  WIDTH_PC  PC of instruction being fetched.
REQ-009 fetch_inst  input  32  instruction word at fetch_pc.
REQ-010 pred_taken  output  1  prediction: redirect fetch to pred_pc (1) or sequential (0).
REQ-011 pred_pc  output  WIDTH_PC  predicted next PC.
REQ-012 upd_valid  input  1  resolved conditional branch or JALR from execute.
REQ-013 upd_pc  input  WIDTH_PC  PC of resolved instruction.
REQ-014 upd_taken  input  1  actual direction.
REQ-015 upd_target  input  WIDTH_PC  actual taken target.
REQ-016 upd_mispredict  input  1  pipeline redirect this cycle; qualifies RAS recovery.

Function
REQ-017 Prediction is combinational from fetch_pc, fetch_inst and current state; zero-cycle latency.
REQ-018 Decode: JAL opcode[6:2]=11011, JALR 11001, BRANCH 11000; call = (JAL|JALR) with rd in {x1,x5}; return = JALR with rs1 in {x1,x5} and rd not in {x1,x5}.
REQ-019 BTB index = pc[IDX_BITS+1:2], tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]; entry = valid, tag, target, 2-bit counter.
REQ-020 Prediction priority: (1) JAL -> pred_pc = fetch_pc + sign-extended J-immediate, pred_taken=1; (2) return with RAS non-empty -> RAS top, taken=1; (3) BRANCH or JALR with BTB hit and counter[1]=1 -> entry target, taken=1; (4) otherwise fetch_pc+4, taken=0.
REQ-021 All PC arithmetic modulo 2**WIDTH_PC; carries out discarded.
REQ-022 Update on upd_valid, hit: counter saturating +1 if taken, -1 if not (bounds 0 and 3); target overwritten with upd_target when taken.
REQ-023 Update on upd_valid, miss (invalid or tag mismatch): taken -> allocate valid=1, new tag, upd_target, counter=2; not taken -> no change.
REQ-024 Same-cycle lookup and update to same index: lookup returns pre-update contents.
REQ-025 RAS push on fetch_valid & call: write fetch_pc+4 at top; count increments, saturating at RAS_DEPTH; when full, oldest entry overwritten (circular pointer).
REQ-026 RAS pop on fetch_valid & return & count>0: pointer and count decrement; pop with count=0 does nothing and prediction falls through to (3)/(4).
REQ-027 fetch_valid=0: no RAS change; outputs still driven from current inputs.
REQ-028 upd_mispredict=1: RAS count cleared to 0 that cycle, overriding any same-cycle push/pop; BTB update from same cycle still applied.

Reset
REQ-029 rst_n low asynchronously clears all BTB valid bits, all counters to 1 (weakly not-taken), RAS pointer and count to 0; stored targets/tags are don't-care.
REQ-030 During and right after reset with fetch of non-JAL: pred_taken=0, pred_pc=fetch_pc+4.
REQ-031 Reset asserted mid-update or mid-push: no partial write survives; state equals REQ-029.

Verification
REQ-032 After reset, BRANCH at 0x100 fetched -> pred_taken=0, pred_pc=0x104; upd taken target 0x80 -> next fetch of 0x100 pred_pc=0x80 (counter 2).
REQ-033 Same branch updated not-taken twice from counter 2 -> counter 0; third not-taken keeps 0; four taken updates saturate at 3.
REQ-034 BTB alias: allocate 0x100 (target 0x80), then fetch 0x100+(2**(IDX_BITS+2)) -> miss, pred_pc=pc+4; update it taken -> replaces entry, 0x100 now misses.
REQ-035 JAL x1 at 0x200 imm=+0x40 -> pred_pc=0x240, RAS top 0x204; JALR x0,0(x1) at 0x250 -> pred_pc=0x204, count back to 0.
REQ-036 Five nested calls with RAS_DEPTH=4 -> four returns predict 5th..2nd return addresses, fifth return falls back to BTB/pc+4.
REQ-037 Call fetched in same cycle as upd_mispredict -> RAS count=0 afterwards; following return predicts pc+4.
